digdar_capture_sched: RTL and testbench
=======================================

DIGDAR_CAPTURE_SCHED -- requirements
Module: digdar_capture_sched

Interface
REQ-001 SHALL have parameter SKIP_W, default 16, width of the pulse-skip count.
REQ-002 SHALL have parameter DLY_W, default 16, width of the trigger-delay count.
REQ-003 SHALL have port adc_clk_i, in, 1, the only clock; all logic is on its rising edge.
REQ-004 SHALL have port adc_rstn_i, in, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port cfg_enable_i, in, 1, level that runs the scheduler.
REQ-006 SHALL have port cfg_skip_i, in, SKIP_W; capture one radar pulse out of every cfg_skip_i+1.
REQ-007 SHALL have port cfg_delay_i, in, DLY_W, cycles from the accepted radar pulse to trig_o.
REQ-008 SHALL have port cfg_max_i, in, 32, number of captures before DONE; 0 means unlimited.
REQ-009 SHALL have ports radar_trig_i, acp_trig_i and arp_trig_i, in, 1 each, single-cycle event pulses.
REQ-010 SHALL have port capturing_i, in, 1, the scope's capture-active level.
REQ-011 SHALL have port sw_ack_i, in, 1, single-cycle pulse from software meaning the buffer has been consumed.
REQ-012 SHALL have ports arm_o, trig_o and abort_o, out, 1 each, single-cycle pulses to the scope: arm, software trigger, reset.
REQ-013 SHALL have ports buf_ready_o and done_o, out, 1 each, levels.
REQ-014 SHALL have ports meta_clock_o, meta_pulse_o and cap_count_o, out, 32 each.
REQ-015 SHALL have ports meta_acp_o, out, 16, and missed_o, out, 16.

Function
REQ-016 SHALL implement the states IDLE, WAIT_PULSE, DELAY, CAP_START, CAP_RUN, READY and DONE.
REQ-017 In IDLE with cfg_enable_i=1, SHALL pulse arm_o, load skip_cnt=cfg_skip_i and enter WAIT_PULSE in the next cycle.
REQ-018 In WAIT_PULSE, a radar_trig_i with skip_cnt!=0 SHALL decrement skip_cnt; with skip_cnt=0 it SHALL load dly_cnt=cfg_delay_i and enter DELAY.
REQ-019 In DELAY with dly_cnt=0, SHALL pulse trig_o and enter CAP_START; otherwise it SHALL decrement dly_cnt; trig_o therefore follows the accepted radar_trig_i by cfg_delay_i+1 cycles.
REQ-020 In the cycle trig_o asserts, SHALL latch meta_clock_o=free-running 32-bit cycle counter, meta_pulse_o=radar pulse count and meta_acp_o=ACP-since-ARP count.
REQ-021 In CAP_START, SHALL move to CAP_RUN when capturing_i=1; if capturing_i stays 0 for 8 cycles, SHALL pulse abort_o and return to WAIT_PULSE with arm_o pulsed.
REQ-022 In CAP_RUN, SHALL enter READY on capturing_i=0 and increment cap_count_o.
REQ-023 In READY, SHALL hold buf_ready_o=1.
REQ-024 In READY, on sw_ack_i, SHALL enter DONE if cfg_max_i!=0 and cap_count_o>=cfg_max_i; otherwise it SHALL pulse arm_o, reload skip_cnt and enter WAIT_PULSE.
REQ-025 sw_ack_i outside READY SHALL be ignored.
REQ-026 done_o SHALL equal 1 only in DONE.
REQ-027 DONE SHALL be left only via cfg_enable_i=0.
REQ-028 cfg_enable_i=0 in any non-IDLE state SHALL pulse abort_o and enter IDLE next cycle, clearing buf_ready_o.
REQ-029 cap_count_o and missed_o SHALL clear on IDLE to WAIT_PULSE.
REQ-030 radar_trig_i in DELAY, CAP_START, CAP_RUN or READY SHALL increment missed_o, saturating at 16'hFFFF.
REQ-031 The radar pulse count SHALL increment on every radar_trig_i while cfg_enable_i=1 and SHALL wrap at 2^32.
REQ-032 The ACP-since-ARP count SHALL reset to 0 on arp_trig_i and increment on acp_trig_i, wrapping at 2^16; when both arrive in the same cycle, arp_trig_i wins and the count becomes 0.
REQ-033 Configuration inputs SHALL be sampled only at load points, so changes mid-sequence take effect at the next load.

Reset
REQ-034 Reset SHALL force state=IDLE.
REQ-035 Reset SHALL force all pulse and level outputs to 0 and all counters and meta registers to 0.
REQ-036 Reset asserted mid-capture SHALL NOT emit abort_o.

Structure
REQ-037 The state encoding and the CAP_START timeout constant (8) SHALL live in a shared package digdar_pkg.
REQ-038 One sub-module, digdar_event_counters, SHALL hold the cycle, radar and ACP/ARP counters; the FSM SHALL be in the top module.

Verification
REQ-039 With skip=0, delay=0, max=1: enable, then radar_trig -> trig_o 1 cycle later; capturing 1 for 20 cycles -> buf_ready_o; sw_ack -> done_o=1, cap_count_o=1.
REQ-040 With skip=2, delay=5: six radar_trigs spaced 100 cycles, capturing driven by the bench 10 cycles per trig_o, each READY acked promptly -> trig_o follows only the 3rd and 6th radar_trig, each 6 cycles after it.
REQ-041 Hold READY without ack while 3 radar_trigs arrive -> missed_o=3 and no trig_o.
REQ-042 capturing_i never asserted after trig_o -> abort_o at the 8th cycle, then arm_o, and state WAIT_PULSE.
REQ-043 acp_trig x5, then arp_trig and acp_trig in the same cycle, then acp_trig x2, then trig -> meta_acp_o=2.
REQ-044 Drop cfg_enable_i in CAP_RUN -> abort_o pulse, IDLE, buf_ready_o=0; async reset mid-DELAY -> all outputs 0 immediately.

Source files
------------

// File: rtl/digdar_pkg.sv
// Shared types and constants for the digdar capture scheduler.
// State encoding, CAP_START timeout and small helpers.
package digdar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PULSE,
        ST_DELAY,
        ST_CAP_START,
        ST_CAP_RUN,
        ST_READY,
        ST_DONE
    } state_e;

    localparam int unsigned CAP_TMO = 8;
    localparam int TMO_W = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/digdar_event_counters.sv
// Free-running cycle counter, radar pulse counter and ACP-since-ARP
// counter feeding the scheduler's metadata latch.
module digdar_event_counters
    import digdar_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        enable_i,
    input  logic        radar_i,
    input  logic        acp_i,
    input  logic        arp_i,
    output logic [31:0] cycle_o,
    output logic [31:0] pulse_o,
    output logic [15:0] acp_o
);

    logic [31:0] cycle_q;
    logic [31:0] pulse_q;
    logic [15:0] acp_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cycle_q <= '0;
            pulse_q <= '0;
            acp_q   <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (radar_i && enable_i)
                pulse_q <= pulse_q + 32'd1;
            // ARP marks the azimuth origin, so it beats a coincident ACP
            if (arp_i)
                acp_q <= '0;
            else if (acp_i)
                acp_q <= acp_q + 16'd1;
        end
    end

    assign cycle_o = cycle_q;
    assign pulse_o = pulse_q;
    assign acp_o   = acp_q;

endmodule

// File: rtl/digdar_capture_sched.sv
// Radar-synchronous capture scheduler: arms the scope, fires a delayed
// software trigger on every Nth radar pulse and hands buffers to software.
module digdar_capture_sched
    import digdar_pkg::*;
#(
    parameter int SKIP_W = 16,
    parameter int DLY_W  = 16
) (
    input  logic              adc_clk_i,
    input  logic              adc_rstn_i,
    input  logic              cfg_enable_i,
    input  logic [SKIP_W-1:0] cfg_skip_i,
    input  logic [DLY_W-1:0]  cfg_delay_i,
    input  logic [31:0]       cfg_max_i,
    input  logic              radar_trig_i,
    input  logic              acp_trig_i,
    input  logic              arp_trig_i,
    input  logic              capturing_i,
    input  logic              sw_ack_i,
    output logic              arm_o,
    output logic              trig_o,
    output logic              abort_o,
    output logic              buf_ready_o,
    output logic              done_o,
    output logic [31:0]       meta_clock_o,
    output logic [31:0]       meta_pulse_o,
    output logic [31:0]       cap_count_o,
    output logic [15:0]       meta_acp_o,
    output logic [15:0]       missed_o
);

    logic [31:0] cycle_cnt;
    logic [31:0] pulse_cnt;
    logic [15:0] acp_cnt;

    digdar_event_counters u_cnt (
        .clk_i    (adc_clk_i),
        .rstn_i   (adc_rstn_i),
        .enable_i (cfg_enable_i),
        .radar_i  (radar_trig_i),
        .acp_i    (acp_trig_i),
        .arp_i    (arp_trig_i),
        .cycle_o  (cycle_cnt),
        .pulse_o  (pulse_cnt),
        .acp_o    (acp_cnt)
    );

    state_e            state_q;
    logic [SKIP_W-1:0] skip_q;
    logic [DLY_W-1:0]  dly_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              rearm_q;
    logic              arm_q;
    logic              trig_q;
    logic              abort_q;
    logic              buf_ready_q;
    logic              done_q;
    logic [31:0]       meta_clock_q;
    logic [31:0]       meta_pulse_q;
    logic [15:0]       meta_acp_q;
    logic [31:0]       cap_cnt_q;
    logic [15:0]       missed_q;
    logic              busy;

    assign busy = (state_q == ST_DELAY) || (state_q == ST_CAP_START) ||
                  (state_q == ST_CAP_RUN) || (state_q == ST_READY);

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q      <= ST_IDLE;
            skip_q       <= '0;
            dly_q        <= '0;
            tmo_q        <= '0;
            rearm_q      <= 1'b0;
            arm_q        <= 1'b0;
            trig_q       <= 1'b0;
            abort_q      <= 1'b0;
            buf_ready_q  <= 1'b0;
            done_q       <= 1'b0;
            meta_clock_q <= '0;
            meta_pulse_q <= '0;
            meta_acp_q   <= '0;
            cap_cnt_q    <= '0;
            missed_q     <= '0;
        end else begin
            arm_q   <= 1'b0;
            trig_q  <= 1'b0;
            abort_q <= 1'b0;
            if (radar_trig_i && busy)
                missed_q <= sat_inc16(missed_q);
            if (!cfg_enable_i) begin
                if (state_q != ST_IDLE) begin
                    abort_q     <= 1'b1;
                    buf_ready_q <= 1'b0;
                    done_q      <= 1'b0;
                    rearm_q     <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        arm_q     <= 1'b1;
                        skip_q    <= cfg_skip_i;
                        cap_cnt_q <= '0;
                        missed_q  <= '0;
                        state_q   <= ST_WAIT_PULSE;
                    end
                    ST_WAIT_PULSE: begin
                        // re-arm after a timeout abort lands one cycle later
                        if (rearm_q) begin
                            arm_q   <= 1'b1;
                            rearm_q <= 1'b0;
                        end
                        if (radar_trig_i) begin
                            if (skip_q != '0) begin
                                skip_q <= skip_q - SKIP_W'(1);
                            end else begin
                                dly_q   <= cfg_delay_i;
                                state_q <= ST_DELAY;
                            end
                        end
                    end
                    ST_DELAY: begin
                        if (dly_q == '0) begin
                            trig_q       <= 1'b1;
                            meta_clock_q <= cycle_cnt;
                            meta_pulse_q <= pulse_cnt;
                            meta_acp_q   <= acp_cnt;
                            tmo_q        <= '0;
                            state_q      <= ST_CAP_START;
                        end else begin
                            dly_q <= dly_q - DLY_W'(1);
                        end
                    end
                    ST_CAP_START: begin
                        if (capturing_i) begin
                            state_q <= ST_CAP_RUN;
                        end else if (tmo_q == TMO_W'(CAP_TMO - 1)) begin
                            abort_q <= 1'b1;
                            rearm_q <= 1'b1;
                            skip_q  <= cfg_skip_i;
                            state_q <= ST_WAIT_PULSE;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    ST_CAP_RUN: begin
                        if (!capturing_i) begin
                            cap_cnt_q   <= cap_cnt_q + 32'd1;
                            buf_ready_q <= 1'b1;
                            state_q     <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (sw_ack_i) begin
                            buf_ready_q <= 1'b0;
                            if (cfg_max_i != '0 && cap_cnt_q >= cfg_max_i) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else begin
                                arm_q   <= 1'b1;
                                skip_q  <= cfg_skip_i;
                                state_q <= ST_WAIT_PULSE;
                            end
                        end
                    end
                    ST_DONE: begin
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign arm_o        = arm_q;
    assign trig_o       = trig_q;
    assign abort_o      = abort_q;
    assign buf_ready_o  = buf_ready_q;
    assign done_o       = done_q;
    assign meta_clock_o = meta_clock_q;
    assign meta_pulse_o = meta_pulse_q;
    assign meta_acp_o   = meta_acp_q;
    assign cap_count_o  = cap_cnt_q;
    assign missed_o     = missed_q;

endmodule

// File: tb/tb_digdar_capture_sched.sv
// Bench for digdar_capture_sched: config table, corner sequences and
// randomized pulse trains against a pulse-index reference model.
module tb_digdar_capture_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] skip = '0;
    logic [15:0] dly = '0;
    logic [31:0] cmax = '0;
    logic        radar = 1'b0;
    logic        acp = 1'b0;
    logic        arp = 1'b0;
    logic        capt = 1'b0;
    logic        ack = 1'b0;
    logic        arm_o, trig_o, abort_o, buf_ready_o, done_o;
    logic [31:0] meta_clock_o, meta_pulse_o, cap_count_o;
    logic [15:0] meta_acp_o, missed_o;

    always #5 clk = ~clk;

    digdar_capture_sched dut (
        .adc_clk_i    (clk),
        .adc_rstn_i   (rst_n),
        .cfg_enable_i (en),
        .cfg_skip_i   (skip),
        .cfg_delay_i  (dly),
        .cfg_max_i    (cmax),
        .radar_trig_i (radar),
        .acp_trig_i   (acp),
        .arp_trig_i   (arp),
        .capturing_i  (capt),
        .sw_ack_i     (ack),
        .arm_o        (arm_o),
        .trig_o       (trig_o),
        .abort_o      (abort_o),
        .buf_ready_o  (buf_ready_o),
        .done_o       (done_o),
        .meta_clock_o (meta_clock_o),
        .meta_pulse_o (meta_pulse_o),
        .cap_count_o  (cap_count_o),
        .meta_acp_o   (meta_acp_o),
        .missed_o     (missed_o)
    );

    typedef struct {
        int skip;
        int delay;
        int max;
        int nrad;
        int period;
        int cap_len;
        int exp_cap;
        bit exp_done;
    } vec_t;

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    int n_trig = 0;
    int last_trig = -1;
    int last_abort = -1;
    int last_arm = -1;
    logic [31:0] m_pulse = '0;
    logic [15:0] m_acp = '0;
    int m_skip, m_delay, m_max, m_k, m_caps;
    int exp_trig[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // one clock: snapshot model counters, clock, update model, observe
    task automatic step();
        logic [31:0] pre_pulse;
        logic [15:0] pre_acp;
        pre_pulse = m_pulse;
        pre_acp = m_acp;
        @(posedge clk);
        #1;
        cyc++;
        if (en && radar) m_pulse++;
        if (arp) m_acp = '0;
        else if (acp) m_acp++;
        if (trig_o) begin
            n_trig++;
            last_trig = cyc;
            if (exp_trig.size() == 0) begin
                chk("trig_o_unexpected", trig_o, 0);
            end else begin
                chk("trig_cycle", cyc, exp_trig.pop_front());
                chk("meta_clock", meta_clock_o, cyc - 1);
                chk("meta_pulse", meta_pulse_o, pre_pulse);
                chk("meta_acp", meta_acp_o, pre_acp);
            end
        end
        if (abort_o) last_abort = cyc;
        if (arm_o) last_arm = cyc;
    endtask

    task automatic start_seq(input int s, input int d, input int m);
        en = 1'b0;
        repeat (3) step();
        skip = 16'(s);
        dly = 16'(d);
        cmax = 32'(m);
        m_skip = s;
        m_delay = d;
        m_max = m;
        m_k = 0;
        m_caps = 0;
        exp_trig.delete();
        en = 1'b1;
        step();
        chk("arm_on_enable", arm_o, 1);
        chk("cap_count_clear", cap_count_o, 0);
        chk("missed_clear", missed_o, 0);
    endtask

    task automatic run_pulses(input int n, input int period, input int cap_len,
                              input bit rnd, input bit auto_ack);
        int cap_left;
        bit ack_pend;
        cap_left = 0;
        ack_pend = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < period; c++) begin
                radar = (c == 0);
                if (c == 0) begin
                    m_k++;
                    if ((m_k % (m_skip + 1)) == 0 &&
                        (m_max == 0 || m_caps < m_max)) begin
                        exp_trig.push_back(cyc + 1 + m_delay + 1);
                        m_caps++;
                    end
                end
                acp = rnd && ($urandom_range(0, 3) == 0);
                arp = rnd && ($urandom_range(0, 15) == 0);
                capt = (cap_left > 0);
                ack = ack_pend;
                step();
                if (cap_left > 0) cap_left--;
                if (trig_o) cap_left = cap_len;
                ack_pend = auto_ack && buf_ready_o && !ack;
            end
        end
        radar = 1'b0;
        acp = 1'b0;
        arp = 1'b0;
        capt = 1'b0;
        ack = 1'b0;
    endtask

    task automatic stop_seq();
        en = 1'b0;
        step();
        chk("abort_on_disable", abort_o, 1);
        chk("done_after_disable", done_o, 0);
        chk("ready_after_disable", buf_ready_o, 0);
    endtask

    initial begin
        vec_t tbl[6];
        int saved;
        tbl[0] = '{0, 0, 1, 1, 40, 20, 1, 1'b1};
        tbl[1] = '{2, 5, 0, 6, 100, 10, 2, 1'b0};
        tbl[2] = '{1, 3, 2, 6, 40, 4, 2, 1'b1};
        tbl[3] = '{0, 7, 0, 3, 40, 6, 3, 1'b0};
        tbl[4] = '{3, 0, 0, 3, 30, 3, 0, 1'b0};
        tbl[5] = '{0, 2, 3, 5, 30, 3, 3, 1'b1};

        #23;
        chk("rst_arm", arm_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_meta_clock", meta_clock_o, 0);
        rst_n = 1'b1;
        cyc = 0;

        for (int i = 0; i < 6; i++) begin
            start_seq(tbl[i].skip, tbl[i].delay, tbl[i].max);
            run_pulses(tbl[i].nrad, tbl[i].period, tbl[i].cap_len, 1'b0, 1'b1);
            chk("tbl_cap_count", cap_count_o, tbl[i].exp_cap);
            chk("tbl_done", done_o, tbl[i].exp_done);
            chk("tbl_missed", missed_o, 0);
            chk("tbl_trig_pending", exp_trig.size(), 0);
            stop_seq();
        end

        // READY held without ack: later pulses counted as missed
        start_seq(0, 0, 0);
        run_pulses(1, 12, 5, 1'b0, 1'b0);
        chk("hold_ready", buf_ready_o, 1);
        saved = n_trig;
        for (int i = 0; i < 3; i++) begin
            radar = 1'b1;
            step();
            radar = 1'b0;
            repeat (3) step();
        end
        chk("missed_3", missed_o, 3);
        chk("no_trig_in_ready", n_trig, saved);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_rearm", arm_o, 1);
        chk("ack_clears_ready", buf_ready_o, 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_ignored", arm_o, 0);
        stop_seq();

        // capture never starts: timeout abort then re-arm
        start_seq(0, 3, 0);
        exp_trig.push_back(cyc + 1 + 4);
        radar = 1'b1;
        step();
        radar = 1'b0;
        repeat (20) step();
        chk("tmo_abort_cycle", last_abort, last_trig + 8);
        chk("tmo_rearm_cycle", last_arm, last_trig + 9);
        saved = n_trig;
        exp_trig.push_back(cyc + 1 + 4);
        radar = 1'b1;
        step();
        radar = 1'b0;
        repeat (6) step();
        chk("retrig_after_tmo", n_trig, saved + 1);
        stop_seq();

        // ACP/ARP collision: ARP wins
        start_seq(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            acp = 1'b1;
            step();
            acp = 1'b0;
            step();
        end
        acp = 1'b1;
        arp = 1'b1;
        step();
        arp = 1'b0;
        acp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            acp = 1'b1;
            step();
            acp = 1'b0;
            step();
        end
        exp_trig.push_back(cyc + 2);
        radar = 1'b1;
        step();
        radar = 1'b0;
        step();
        chk("meta_acp_2", meta_acp_o, 2);
        stop_seq();

        // disable in CAP_RUN
        start_seq(0, 0, 0);
        exp_trig.push_back(cyc + 2);
        radar = 1'b1;
        step();
        radar = 1'b0;
        step();
        capt = 1'b1;
        repeat (5) step();
        en = 1'b0;
        step();
        chk("caprun_abort", abort_o, 1);
        chk("caprun_ready", buf_ready_o, 0);
        capt = 1'b0;
        step();
        chk("caprun_idle_no_arm", arm_o, 0);

        // asynchronous reset during DELAY
        start_seq(0, 20, 0);
        radar = 1'b1;
        step();
        radar = 1'b0;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_arm_o", arm_o, 0);
        chk("rst_trig_o", trig_o, 0);
        chk("rst_abort_o", abort_o, 0);
        chk("rst_buf_ready", buf_ready_o, 0);
        chk("rst_done_o", done_o, 0);
        chk("rst_meta_clock2", meta_clock_o, 0);
        chk("rst_meta_pulse", meta_pulse_o, 0);
        chk("rst_meta_acp", meta_acp_o, 0);
        chk("rst_cap_count", cap_count_o, 0);
        chk("rst_missed", missed_o, 0);
        #2 rst_n = 1'b1;
        cyc = 0;
        m_pulse = '0;
        m_acp = '0;
        exp_trig.delete();
        last_abort = -1;
        saved = n_trig;
        step();
        chk("arm_after_reset", arm_o, 1);
        repeat (30) step();
        chk("no_trig_after_reset", n_trig, saved);
        chk("no_abort_on_reset", last_abort, -1);
        stop_seq();

        // randomized pulse trains
        for (int r = 0; r < 6; r++) begin
            start_seq($urandom_range(0, 3), $urandom_range(0, 20),
                      $urandom_range(0, 3));
            run_pulses(8, 40, $urandom_range(2, 10), 1'b1, 1'b1);
            chk("rnd_cap_count", cap_count_o, m_caps);
            chk("rnd_done", done_o, (m_max != 0 && m_caps >= m_max));
            chk("rnd_trig_pending", exp_trig.size(), 0);
            stop_seq();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
